// File: rtl/servisia_mem_ctrl.sv
// Wishbone-to-byte-memory bridge: each 32-bit bus access becomes four sequential
// byte accesses on an 8-bit memory whose read data arrives one cycle after the strobe.
module servisia_mem_ctrl (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        wb_cyc_i,
  input  logic        wb_we_i,
  input  logic [31:0] wb_adr_i,
  input  logic [3:0]  wb_sel_i,
  input  logic [31:0] wb_dat_i,
  output logic [31:0] wb_dat_o,
  output logic        wb_ack_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic [19:0] mem_addr_o,
  output logic [7:0]  mem_wdata_o,
  input  logic [7:0]  mem_rdata_i
);

  typedef enum logic [2:0] {StIdle, StRd, StRdLast, StWr, StAck} state_e;

  state_e          state_q, state_d;
  logic [1:0]      cnt_q, cnt_d;
  logic [17:0]     adr_q;
  logic            we_q;
  logic [3:0]      sel_q;
  logic [3:0][7:0] dat_q;
  logic [3:0][7:0] rbuf_q;

  logic            accept;
  logic            cap_en;
  logic [1:0]      cap_idx;

  // Address bits outside [19:2] are deliberately ignored.
  logic unused_adr;
  assign unused_adr = ^{wb_adr_i[31:20], wb_adr_i[1:0]};

  // State, byte counter, latched request and read buffer.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= StIdle;
      cnt_q   <= 2'd0;
      adr_q   <= '0;
      we_q    <= 1'b0;
      sel_q   <= '0;
      dat_q   <= '0;
      rbuf_q  <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (accept) begin
        adr_q <= wb_adr_i[19:2];
        we_q  <= wb_we_i;
        sel_q <= wb_sel_i;
        dat_q <= wb_dat_i;
      end
      if (cap_en) begin
        rbuf_q[cap_idx] <= mem_rdata_i;
      end
    end
  end

  // Next-state logic and memory/bus strobes.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    accept      = 1'b0;
    cap_en      = 1'b0;
    // Memory data lags the strobe by one cycle, so byte k-1 arrives while cnt=k.
    cap_idx     = cnt_q - 2'd1;
    wb_ack_o    = 1'b0;
    mem_read_o  = 1'b0;
    mem_write_o = 1'b0;
    mem_addr_o  = '0;
    mem_wdata_o = '0;
    case (state_q)
      StIdle: begin
        if (wb_cyc_i) begin
          accept  = 1'b1;
          cnt_d   = 2'd0;
          state_d = wb_we_i ? StWr : StRd;
        end
      end
      StRd: begin
        mem_read_o = 1'b1;
        mem_addr_o = {adr_q, cnt_q};
        cap_en     = (cnt_q != 2'd0);
        cnt_d      = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StRdLast;
      end
      StRdLast: begin
        cap_en  = 1'b1;
        cap_idx = 2'd3;
        state_d = StAck;
      end
      StWr: begin
        mem_addr_o  = {adr_q, cnt_q};
        mem_wdata_o = dat_q[cnt_q];
        mem_write_o = sel_q[cnt_q];
        cnt_d       = cnt_q + 2'd1;
        if (cnt_q == 2'd3) state_d = StAck;
      end
      StAck: begin
        wb_ack_o = 1'b1;
        state_d  = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  assign wb_dat_o = rbuf_q;

endmodule

// File: tb/tb_servisia_mem_ctrl.sv
// Directed bench for servisia_mem_ctrl with a byte memory model that returns
// read data one cycle after the read strobe.
module tb_servisia_mem_ctrl;

  logic        clk;
  logic        rst_n;
  logic        wb_cyc;
  logic        wb_we;
  logic [31:0] wb_adr;
  logic [3:0]  wb_sel;
  logic [31:0] wb_dat_w;
  logic [31:0] wb_dat_r;
  logic        wb_ack;
  logic        mem_read;
  logic        mem_write;
  logic [19:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic [7:0]  mem_rdata;

  int asserts = 0;
  int fails   = 0;

  // Per-transaction observations
  logic [19:0] rd_addr[$];
  int          rd_cyc[$];
  logic [19:0] wr_addr[$];
  logic [7:0]  wr_data[$];
  int          ack_cyc;
  int          ack_cnt;
  int          overlap;
  logic        ack_after;

  servisia_mem_ctrl dut (
    .clk_i       (clk),
    .rst_ni      (rst_n),
    .wb_cyc_i    (wb_cyc),
    .wb_we_i     (wb_we),
    .wb_adr_i    (wb_adr),
    .wb_sel_i    (wb_sel),
    .wb_dat_i    (wb_dat_w),
    .wb_dat_o    (wb_dat_r),
    .wb_ack_o    (wb_ack),
    .mem_read_o  (mem_read),
    .mem_write_o (mem_write),
    .mem_addr_o  (mem_addr),
    .mem_wdata_o (mem_wdata),
    .mem_rdata_i (mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [7:0] mem_byte(input logic [19:0] a);
    case (a)
      20'h00010: mem_byte = 8'h11;
      20'h00011: mem_byte = 8'h22;
      20'h00012: mem_byte = 8'h33;
      20'h00013: mem_byte = 8'h44;
      default:   mem_byte = a[7:0] + 8'h30 + (a[19] ? 8'h80 : 8'h00);
    endcase
  endfunction

  // Memory registers its read data one cycle after the strobe.
  initial mem_rdata = 8'h00;
  always @(posedge clk) if (mem_read) mem_rdata <= mem_byte(mem_addr);

  // Issue one request and record memory activity; cycle n is the n-th cycle after acceptance.
  task automatic run_txn(input logic we, input logic [31:0] adr, input logic [3:0] sel,
                         input logic [31:0] dat);
    rd_addr.delete(); rd_cyc.delete(); wr_addr.delete(); wr_data.delete();
    ack_cyc = 0; ack_cnt = 0; overlap = 0; ack_after = 1'bx;
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = we; wb_adr = adr; wb_sel = sel; wb_dat_w = dat;
    @(posedge clk); #1;
    for (int n = 1; n <= 20; n++) begin
      if (mem_read && mem_write) overlap++;
      if (mem_read) begin rd_addr.push_back(mem_addr); rd_cyc.push_back(n); end
      if (mem_write) begin wr_addr.push_back(mem_addr); wr_data.push_back(mem_wdata); end
      if (wb_ack) begin
        ack_cnt++;
        ack_cyc = n;
        wb_cyc  = 1'b0;
        @(posedge clk); #1;
        ack_after = wb_ack;
        break;
      end
      @(posedge clk); #1;
    end
    wb_cyc = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; wb_cyc = 0; wb_we = 0; wb_adr = 0; wb_sel = 0; wb_dat_w = 0;
    #2;
    asserts++;
    if ({mem_read, mem_write, wb_ack, mem_addr, mem_wdata} !== 31'd0) begin
      fails++;
      $display("FAIL reset_strobes: got rd=%b wr=%b ack=%b addr=%h wdata=%h, want all 0",
               mem_read, mem_write, wb_ack, mem_addr, mem_wdata);
    end
    asserts++;
    if (wb_dat_r !== 32'h0) begin
      fails++; $display("FAIL reset_dat: got %h want 00000000", wb_dat_r);
    end
    @(negedge clk); rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_read_basic();
    run_txn(1'b0, 32'h0000_0010, 4'b0000, 32'h0);
    asserts++;
    if (rd_addr.size() != 4) begin
      fails++; $display("FAIL read_count: got %0d reads want 4", rd_addr.size());
    end
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if ((i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx) !== 20'h00010 + 20'(i) ||
          (i < rd_cyc.size() ? rd_cyc[i] : -1) != i + 1) begin
        fails++;
        $display("FAIL read_addr[%0d]: got addr=%h cyc=%0d want addr=%h cyc=%0d", i,
                 i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx,
                 i < rd_cyc.size() ? rd_cyc[i] : -1, 20'h00010 + 20'(i), i + 1);
      end
    end
    asserts++;
    if (ack_cyc != 6) begin fails++; $display("FAIL read_ack_cyc: got %0d want 6", ack_cyc); end
    asserts++;
    if (ack_after !== 1'b0) begin
      fails++; $display("FAIL read_ack_width: ack after pulse %b want 0", ack_after);
    end
    asserts++;
    if (wb_dat_r !== 32'h4433_2211) begin
      fails++; $display("FAIL read_data: got %h want 44332211", wb_dat_r);
    end
  endtask

  task automatic test_write_sel();
    run_txn(1'b1, 32'h0008_0004, 4'b0101, 32'hAABB_CCDD);
    asserts++;
    if (wr_addr.size() != 2 || rd_addr.size() != 0) begin
      fails++;
      $display("FAIL write_count: got %0d writes %0d reads want 2 and 0", wr_addr.size(),
               rd_addr.size());
    end
    asserts++;
    if (wr_addr.size() < 2 || wr_addr[0] !== 20'h80004 || wr_data[0] !== 8'hDD ||
        wr_addr[1] !== 20'h80006 || wr_data[1] !== 8'hBB) begin
      fails++;
      $display("FAIL write_bytes: got %0d writes, first %h/%h, want 80004/dd then 80006/bb",
               wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 20'hxxxxx,
               wr_data.size() > 0 ? wr_data[0] : 8'hxx);
    end
    asserts++;
    if (ack_cyc != 5) begin fails++; $display("FAIL write_ack_cyc: got %0d want 5", ack_cyc); end
    asserts++;
    if (wb_dat_r !== 32'h4433_2211) begin
      fails++; $display("FAIL write_keeps_dat: got %h want 44332211", wb_dat_r);
    end
  endtask

  task automatic test_write_nosel();
    run_txn(1'b1, 32'h0000_0040, 4'b0000, 32'h1234_5678);
    asserts++;
    if (wr_addr.size() != 0) begin
      fails++; $display("FAIL nosel_writes: got %0d write pulses want 0", wr_addr.size());
    end
    asserts++;
    if (ack_cyc != 5) begin fails++; $display("FAIL nosel_ack_cyc: got %0d want 5", ack_cyc); end
  endtask

  task automatic test_read_high_addr();
    run_txn(1'b0, 32'hFFF8_0008, 4'b1111, 32'h0);
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if ((i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx) !== 20'h80008 + 20'(i)) begin
        fails++;
        $display("FAIL high_addr[%0d]: got %h want %h", i,
                 i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx, 20'h80008 + 20'(i));
      end
    end
    asserts++;
    if (overlap != 0) begin fails++; $display("FAIL rd_wr_overlap: got %0d want 0", overlap); end
    asserts++;
    if (wb_dat_r !== 32'hBBBA_B9B8) begin
      fails++; $display("FAIL high_data: got %h want bbbab9b8", wb_dat_r);
    end
  endtask

  task automatic test_back_to_back();
    run_txn(1'b0, 32'h0000_0010, 4'b1111, 32'h0);
    asserts++;
    if (ack_cyc != 6 || wb_dat_r !== 32'h4433_2211) begin
      fails++;
      $display("FAIL b2b_read: got ack_cyc=%0d dat=%h want 6 and 44332211", ack_cyc, wb_dat_r);
    end
    run_txn(1'b1, 32'h0000_0020, 4'b1111, 32'h1234_5678);
    asserts++;
    if (ack_cyc != 5) begin fails++; $display("FAIL b2b_write_ack: got %0d want 5", ack_cyc); end
    asserts++;
    if (wr_addr.size() != 4 || wr_addr[0] !== 20'h00020 || wr_data[0] !== 8'h78 ||
        wr_addr[3] !== 20'h00023 || wr_data[3] !== 8'h12) begin
      fails++;
      $display("FAIL b2b_write_bytes: got %0d writes, first %h/%h, want 4 starting 00020/78",
               wr_addr.size(), wr_addr.size() > 0 ? wr_addr[0] : 20'hxxxxx,
               wr_data.size() > 0 ? wr_data[0] : 8'hxx);
    end
    asserts++;
    if (wb_dat_r !== 32'h4433_2211) begin
      fails++; $display("FAIL b2b_keeps_dat: got %h want 44332211", wb_dat_r);
    end
  endtask

  task automatic test_reset_mid_read();
    logic seen_ack;
    seen_ack = 1'b0;
    @(negedge clk);
    wb_cyc = 1'b1; wb_we = 1'b0; wb_adr = 32'h0000_0100; wb_sel = 4'hF;
    @(posedge clk); #1;  // cycle 1, cnt=0
    @(posedge clk); #1;  // cycle 2, cnt=1
    @(posedge clk); #1;  // cycle 3, cnt=2
    asserts++;
    if (mem_read !== 1'b1 || mem_addr !== 20'h00102) begin
      fails++;
      $display("FAIL mid_read_pre: got rd=%b addr=%h want 1 and 00102", mem_read, mem_addr);
    end
    #2 rst_n = 1'b0;
    #1;
    asserts++;
    if ({mem_read, mem_write, wb_ack, mem_addr, mem_wdata} !== 31'd0 || wb_dat_r !== 32'h0) begin
      fails++;
      $display("FAIL mid_read_reset: got rd=%b wr=%b ack=%b addr=%h wdata=%h dat=%h want all 0",
               mem_read, mem_write, wb_ack, mem_addr, mem_wdata, wb_dat_r);
    end
    wb_cyc = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      if (wb_ack) seen_ack = 1'b1;
    end
    @(negedge clk); rst_n = 1'b1;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (wb_ack) seen_ack = 1'b1;
    end
    asserts++;
    if (seen_ack !== 1'b0) begin fails++; $display("FAIL mid_read_no_ack: got ack=1 want 0"); end
    run_txn(1'b0, 32'h0000_0000, 4'b1111, 32'h0);
    for (int i = 0; i < 4; i++) begin
      asserts++;
      if ((i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx) !== 20'(i)) begin
        fails++;
        $display("FAIL post_reset_addr[%0d]: got %h want %h", i,
                 i < rd_addr.size() ? rd_addr[i] : 20'hxxxxx, 20'(i));
      end
    end
    asserts++;
    if (ack_cyc != 6 || wb_dat_r !== 32'h3332_3130) begin
      fails++;
      $display("FAIL post_reset_read: got ack_cyc=%0d dat=%h want 6 and 33323130",
               ack_cyc, wb_dat_r);
    end
  endtask

  initial begin
    test_reset();
    test_read_basic();
    test_write_sel();
    test_write_nosel();
    test_read_high_addr();
    test_back_to_back();
    test_reset_mid_read();
    $display("End of test - %0d assertions evaluated, %0d failures", asserts, fails);
    $finish;
  end

endmodule

// File: doc/servisia_mem_ctrl.md
SERVISIA_MEM_CTRL -- requirements
Module: servisia_mem_ctrl

Interface
REQ-001 SHALL have exactly one clock and an asynchronous active-low reset: clk_i and rst_ni.
REQ-002 SHALL provide these ports:
- clk_i  in  1  system clock; all state updates on the rising edge
- rst_ni  in  1  asynchronous active-low reset
- wb_cyc_i  in  1  bus request, held until ack
- wb_we_i  in  1  1 = write, 0 = read
- wb_adr_i  in  32  byte address; only bits [19:2] used
- wb_sel_i  in  4  byte enables for writes
- wb_dat_i  in  32  write data, little-endian
- wb_dat_o  out  32  read data
- wb_ack_o  out  1  one-cycle completion pulse
- mem_read_o  out  1  byte read strobe to the memory
- mem_write_o  out  1  byte write strobe to the memory
- mem_addr_o  out  20  byte address to the memory
- mem_wdata_o  out  8  byte write data
- mem_rdata_i  in  8  byte read data, registered by the memory one cycle after the strobe

Function
REQ-003 SHALL use the states IDLE, RD, RD_LAST, WR and ACK, with a 2-bit byte counter cnt.
REQ-004 In IDLE with wb_cyc_i=1 at a rising edge, SHALL latch wb_adr_i[19:2], wb_we_i, wb_sel_i and wb_dat_i, clear cnt, and go to RD (we=0) or WR (we=1).
REQ-005 A request SHALL be accepted only in IDLE; wb_cyc_i in every other state is ignored.
REQ-006 In RD and WR, SHALL drive mem_addr_o = {latched adr[19:2], cnt}.
REQ-007 In RD, SHALL assert mem_read_o.
- Each edge increments cnt.
- cnt=3 goes to RD_LAST.
REQ-008 In RD with cnt=k and k>=1, SHALL capture mem_rdata_i into read-buffer byte k-1 at the edge.
REQ-009 In RD_LAST, mem_read_o SHALL be 0; the edge captures mem_rdata_i into buffer byte 3 and goes to ACK.
REQ-010 In WR, SHALL drive mem_wdata_o with latched data byte cnt, i.e. bits [8cnt+7:8cnt].
- Assert mem_write_o only when latched sel[cnt]=1.
- Each edge increments cnt.
- cnt=3 goes to ACK.
REQ-011 Unselected write bytes SHALL still take one cycle each; a write with sel=0000 completes with no mem_write_o pulse.
REQ-012 Reads SHALL always fetch all 4 bytes regardless of wb_sel_i.
REQ-013 In ACK, SHALL assert wb_ack_o for exactly one cycle, then go to IDLE.
REQ-014 The requester SHALL drop wb_cyc_i in the cycle after ack; if it is still high in IDLE, that is a new request.
REQ-015 Latency, counted from the acceptance edge:
- read ack in the 6th cycle
- write ack in the 5th cycle
REQ-016 wb_dat_o SHALL be the read buffer, stable from read ack until the next read captures byte 0; writes leave it unchanged.
REQ-017 mem_read_o and mem_write_o SHALL never both be 1.
REQ-018 In IDLE, RD_LAST and ACK, mem_write_o, mem_addr_o and mem_wdata_o SHALL be 0.
REQ-019 wb_adr_i bits [31:20] and [1:0] SHALL be ignored.
REQ-020 Address bit 19 SHALL pass through unmodified; the memory uses it to select flash or SRAM.

Reset
REQ-021 rst_ni=0 SHALL immediately, without waiting for a clock edge:
- force state to IDLE and cnt to 0
- clear the latched request and the read buffer
- drive every output to 0
REQ-022 A reset during RD or WR SHALL abandon the transaction without ack.
- The first request after release restarts from byte 0.

Verification
REQ-023 Read, memory bytes at 0x00010..0x00013 = 11,22,33,44:
- mem_addr_o steps 0x00010..0x00013 in consecutive cycles
- wb_dat_o = 0x44332211
- wb_ack_o high only in cycle 6 after acceptance
REQ-024 Write adr=0x80004, sel=0101, dat=0xAABBCCDD:
- mem_write_o high only at addr 0x80004 (wdata 0xDD) and 0x80006 (wdata 0xBB)
- ack in cycle 5
REQ-025 Read at adr=0xFFF80008:
- mem_addr_o = 0x80008..0x8000B
- mem_read_o never overlaps mem_write_o
REQ-026 Read ack, cyc dropped one cycle, then write request:
- write accepted on the next IDLE edge
- wb_dat_o keeps the earlier read value
REQ-027 rst_ni pulsed low while in RD with cnt=2:
- all outputs 0 immediately and no ack
- after release, a read at 0x00000 with wb_cyc_i=1 issues addresses 0x00000..0x00003 and acks
